// File: rtl/bus_slave_ram.sv
// Word-addressed on-chip RAM bus responder: strobe-accepted request,
// programmable wait states, single-cycle active-low acknowledge.
module bus_slave_ram #(
  parameter int WORDS       = 2048,
  parameter int ADDR_W      = 11,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset_,
  input  logic              CS_,
  input  logic              As_,
  input  logic              RW,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [31:0]       WrData,
  output logic [31:0]       RdData,
  output logic              Rdy_
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READY} state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] addr_r;
  logic              rw_r;
  logic [31:0]       wdata_r;
  logic [31:0]       mem [WORDS];

  logic              accept, enter_ready, rd_rw, rd_ok, wr_ok, wr_en;
  logic [ADDR_W-1:0] rd_addr;

  assign accept = (state == S_IDLE) && !CS_ && !As_;

  // With no wait states the read happens on the acceptance edge, so it must
  // use the live bus rather than the registers being loaded on that edge.
  assign enter_ready = (WAIT_CYCLES == 0) ? accept : ((state == S_WAIT) && (cnt == 4'd0));
  assign rd_addr     = (WAIT_CYCLES == 0) ? Addr : addr_r;
  assign rd_rw       = (WAIT_CYCLES == 0) ? RW   : rw_r;
  assign rd_ok       = 32'(rd_addr) < 32'(WORDS);
  assign wr_ok       = 32'(addr_r)  < 32'(WORDS);

  // Writes always come from the latched registers; the zero-wait case commits
  // while in READY, which still precedes any later transaction's read.
  assign wr_en = !rw_r && wr_ok &&
                 ((WAIT_CYCLES == 0) ? (state == S_READY) : enter_ready);

  always_ff @(posedge clk) begin
    if (wr_en) mem[addr_r] <= wdata_r;
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      addr_r  <= '0;
      rw_r    <= 1'b0;
      wdata_r <= 32'd0;
      RdData  <= 32'd0;
      Rdy_    <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            addr_r  <= Addr;
            rw_r    <= RW;
            wdata_r <= WrData;
            if (WAIT_CYCLES == 0) begin
              state <= S_READY;
            end else begin
              state <= S_WAIT;
              cnt   <= 4'(WAIT_CYCLES - 1);
            end
          end
        end
        S_WAIT: begin
          if (cnt == 4'd0) state <= S_READY;
          else             cnt   <= cnt - 4'd1;
        end
        S_READY: begin
          state  <= S_IDLE;
          Rdy_   <= 1'b1;
          RdData <= 32'd0;
        end
        default: state <= S_IDLE;
      endcase
      if (enter_ready) begin
        Rdy_   <= 1'b0;
        RdData <= (rd_rw && rd_ok) ? mem[rd_addr] : 32'd0;
      end
    end
  end

endmodule
